// File: rtl/pertinencia_trapezio_seq.sv
// Sequential trapezoid membership: grau = min(N1/D1, N2/D2) clipped to 0..SCALE,
// computed with one shared restoring divider that is reused for both terms.
module pertinencia_trapezio_seq #(
    parameter int OUT_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic signed [31:0]      Numerador_1,
    input  logic signed [31:0]      Denominador_1,
    input  logic signed [31:0]      Numerador_2,
    input  logic signed [31:0]      Denominador_2,
    output logic                    busy,
    output logic                    done,
    output logic [OUT_W-1:0]        grau,
    output logic                    erro
);

    localparam int DW = 2 * OUT_W;
    localparam int CW = $clog2(DW + 1);
    localparam logic [OUT_W-1:0] SCALE = {OUT_W{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_DIV1 = 3'd2,
        S_DIV2 = 3'd3,
        S_FIN  = 3'd4,
        S_DONE = 3'd5
    } state_t;

    // Early resolution of one term: {resolved, denominator_error, value}.
    function automatic logic [OUT_W+1:0] classify(input logic signed [31:0] n,
                                                   input logic signed [31:0] d);
        logic [OUT_W+1:0] r;
        if (n < 32'sd0) begin
            r = {1'b1, 1'b0, {OUT_W{1'b0}}};
        end else if (d < 32'sd0) begin
            r = {1'b1, 1'b1, {OUT_W{1'b0}}};
        end else if (d == 32'sd0) begin
            r = {1'b1, 1'b0, SCALE};
        end else if (n >= d) begin
            r = {1'b1, 1'b0, SCALE};
        end else begin
            r = {1'b0, 1'b0, {OUT_W{1'b0}}};
        end
        return r;
    endfunction

    function automatic logic [DW-1:0] dividend(input logic [OUT_W:0] n);
        logic [DW+1:0] p;
        p = (DW+2)'(n) * (DW+2)'(SCALE);
        return p[DW-1:0];
    endfunction

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic signed [31:0]  n1_q, n1_d, d1_q, d1_d, n2_q, n2_d, d2_q, d2_d;
    logic                ovr1_q, ovr1_d, ovr2_q, ovr2_d, err_q, err_d;
    logic [OUT_W-1:0]    res1_q, res1_d, res2_q, res2_d, t1_q, t1_d;
    logic [DW-1:0]       dvd_q, dvd_d;
    logic [OUT_W:0]      dvs_q, dvs_d, rem_q, rem_d;
    logic [OUT_W-1:0]    quo_q, quo_d;
    logic                busy_q, busy_d, done_q, done_d, erro_q, erro_d;
    logic [OUT_W-1:0]    grau_q, grau_d;
    logic [OUT_W+1:0]    c1_s, c2_s;
    logic [OUT_W+1:0]    rem_sh_s;
    logic                ge_s, iter_s;
    logic [OUT_W-1:0]    t2_s;

    // Next-state, divider step and output-register computation.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        n1_d     = n1_q;
        d1_d     = d1_q;
        n2_d     = n2_q;
        d2_d     = d2_q;
        ovr1_d   = ovr1_q;
        ovr2_d   = ovr2_q;
        res1_d   = res1_q;
        res2_d   = res2_q;
        err_d    = err_q;
        t1_d     = t1_q;
        dvd_d    = dvd_q;
        dvs_d    = dvs_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        grau_d   = grau_q;
        erro_d   = erro_q;
        iter_s   = 1'b0;
        c1_s     = classify(n1_q, d1_q);
        c2_s     = classify(n2_q, d2_q);
        t2_s     = ovr2_q ? res2_q : quo_q;
        rem_sh_s = {rem_q, dvd_q[DW-1]};
        ge_s     = (rem_sh_s >= {1'b0, dvs_q});

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    n1_d    = Numerador_1;
                    d1_d    = Denominador_1;
                    n2_d    = Numerador_2;
                    d2_d    = Denominador_2;
                    err_d   = 1'b0;
                    state_d = S_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                ovr1_d  = c1_s[OUT_W+1];
                res1_d  = c1_s[OUT_W-1:0];
                ovr2_d  = c2_s[OUT_W+1];
                res2_d  = c2_s[OUT_W-1:0];
                err_d   = c1_s[OUT_W] | c2_s[OUT_W];
                dvd_d   = dividend(n1_q[OUT_W:0]);
                dvs_d   = d1_q[OUT_W:0];
                rem_d   = {(OUT_W+1){1'b0}};
                quo_d   = {OUT_W{1'b0}};
                cnt_d   = {CW{1'b0}};
                state_d = S_DIV1;
            end
            S_DIV1: begin
                iter_s = 1'b1;
                if (cnt_q == CW'(DW - 1)) begin
                    cnt_d   = {CW{1'b0}};
                    state_d = S_DIV2;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DIV2: begin
                // First DIV2 cycle hands the shared divider over to term 2.
                if (cnt_q == {CW{1'b0}}) begin
                    t1_d  = ovr1_q ? res1_q : quo_q;
                    dvd_d = dividend(n2_q[OUT_W:0]);
                    dvs_d = d2_q[OUT_W:0];
                    rem_d = {(OUT_W+1){1'b0}};
                    quo_d = {OUT_W{1'b0}};
                    cnt_d = CW'(1);
                end else if (cnt_q == CW'(DW)) begin
                    iter_s  = 1'b1;
                    state_d = S_FIN;
                end else begin
                    iter_s = 1'b1;
                    cnt_d  = cnt_q + CW'(1);
                end
            end
            S_FIN: begin
                grau_d  = (t1_q < t2_s) ? t1_q : t2_s;
                erro_d  = err_q;
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (iter_s) begin
            dvd_d = {dvd_q[DW-2:0], 1'b0};
            rem_d = ge_s ? (rem_sh_s[OUT_W:0] - dvs_q) : rem_sh_s[OUT_W:0];
            quo_d = {quo_q[OUT_W-2:0], ge_s};
        end else begin
            iter_s = 1'b0;
        end

        busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d = (state_d == S_DONE);
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= {CW{1'b0}};
            n1_q    <= 32'sd0;
            d1_q    <= 32'sd0;
            n2_q    <= 32'sd0;
            d2_q    <= 32'sd0;
            ovr1_q  <= 1'b0;
            ovr2_q  <= 1'b0;
            res1_q  <= {OUT_W{1'b0}};
            res2_q  <= {OUT_W{1'b0}};
            err_q   <= 1'b0;
            t1_q    <= {OUT_W{1'b0}};
            dvd_q   <= {DW{1'b0}};
            dvs_q   <= {(OUT_W+1){1'b0}};
            rem_q   <= {(OUT_W+1){1'b0}};
            quo_q   <= {OUT_W{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            grau_q  <= {OUT_W{1'b0}};
            erro_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            n1_q    <= n1_d;
            d1_q    <= d1_d;
            n2_q    <= n2_d;
            d2_q    <= d2_d;
            ovr1_q  <= ovr1_d;
            ovr2_q  <= ovr2_d;
            res1_q  <= res1_d;
            res2_q  <= res2_d;
            err_q   <= err_d;
            t1_q    <= t1_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            grau_q  <= grau_d;
            erro_q  <= erro_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign grau = grau_q;
    assign erro = erro_q;

endmodule

// File: tb/tb_pertinencia_trapezio_seq.sv
// Self-checking bench: directed trapezoid cases plus random operands against
// an arithmetic reference of the membership rules.
module tb_pertinencia_trapezio_seq;

    localparam int OUT_W = 8;
    localparam int SCALE = 255;
    localparam int LAT   = 4 * OUT_W + 3;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic signed [31:0] n1, d1, n2, d2;
    logic               busy, done, erro;
    logic [OUT_W-1:0]   grau;

    int checks   = 0;
    int failures = 0;

    pertinencia_trapezio_seq #(.OUT_W(OUT_W)) dut (
        .clk(clk), .rst(rst), .start(start),
        .Numerador_1(n1), .Denominador_1(d1),
        .Numerador_2(n2), .Denominador_2(d2),
        .busy(busy), .done(done), .grau(grau), .erro(erro)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int term(input int n, input int d, output bit e);
        e = 1'b0;
        if (n < 0) return 0;
        if (d < 0) begin
            e = 1'b1;
            return 0;
        end
        if (d == 0) return SCALE;
        if (n >= d) return SCALE;
        return (n * SCALE) / d;
    endfunction

    // One operation: caller is between edges with the DUT idle.
    // poke=1 also pulses start mid-operation and during the done cycle.
    task automatic run_op(input string tag, input int a, input int b, input int c,
                          input int d, input bit poke);
        int  t1, t2, exp_g, lat, bad_busy;
        bit  e1, e2, got;
        t1 = term(a, b, e1);
        t2 = term(c, d, e2);
        exp_g = (t1 < t2) ? t1 : t2;
        n1 = a; d1 = b; n2 = c; d2 = d;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n1 = $urandom; d1 = $urandom; n2 = $urandom; d2 = $urandom;
        bad_busy = (busy === 1'b1) ? 0 : 1;
        got = 1'b0;
        lat = -1;
        for (int e = 1; e <= LAT + 20 && !got; e++) begin
            start = (poke && (e == 10 || e == 20)) ? 1'b1 : 1'b0;
            @(posedge clk); #1;
            if (done === 1'b1) begin
                got = 1'b1;
                lat = e;
            end else if (busy !== 1'b1) begin
                bad_busy++;
            end
        end
        start = 1'b0;
        if (!got) begin
            chk({tag, "_timeout"}, 0, 1);
        end else begin
            chk({tag, "_lat"}, lat, LAT);
            chk({tag, "_busy"}, bad_busy, 0);
            chk({tag, "_grau"}, int'(grau), exp_g);
            chk({tag, "_erro"}, int'(erro), int'(e1 | e2));
            chk({tag, "_busy_at_done"}, int'(busy), 0);
            if (poke) start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            chk({tag, "_done_pulse"}, int'(done), 0);
            chk({tag, "_idle"}, int'(busy), 0);
            chk({tag, "_hold"}, int'(grau), exp_g);
        end
    endtask

    initial begin
        int a, b, c, d, pick;
        rst = 1'b1; start = 1'b0; n1 = 0; d1 = 0; n2 = 0; d2 = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_grau", int'(grau), 0);
        chk("rst_erro", int'(erro), 0);
        rst = 1'b0;

        run_op("x75", 25, 50, 125, 50, 1'b0);
        run_op("x125", 75, 50, 75, 50, 1'b0);
        run_op("x175", 125, 50, 25, 50, 1'b1);
        run_op("x30", -20, 50, 170, 50, 1'b0);
        run_op("x210", 160, 50, -10, 50, 1'b0);
        run_op("shoulder", 0, 0, 200, 50, 1'b0);
        run_op("negden", 5, -10, 200, 50, 1'b0);
        run_op("clr_erro", 1, 3, 2, 3, 1'b0);

        // Reset after the 10th edge of an operation aborts it silently.
        n1 = 25; d1 = 50; n2 = 125; d2 = 50;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_grau", int'(grau), 0);
        chk("abort_erro", int'(erro), 0);
        pick = 0;
        for (int i = 0; i < LAT + 10; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) pick++;
        end
        chk("abort_no_done", pick, 0);
        run_op("after_abort", 40, 100, 60, 100, 1'b0);

        for (int k = 0; k < 24; k++) begin
            a = int'($urandom_range(0, 510)) - 255;
            c = int'($urandom_range(0, 510)) - 255;
            pick = int'($urandom_range(0, 9));
            b = (pick == 0) ? -int'($urandom_range(1, 255)) :
                (pick == 1) ? 0 : int'($urandom_range(1, 255));
            pick = int'($urandom_range(0, 9));
            d = (pick == 0) ? -int'($urandom_range(1, 255)) :
                (pick == 1) ? 0 : int'($urandom_range(1, 255));
            if (k % 3 == 0) begin
                a = int'($urandom_range(0, 254));
                b = int'($urandom_range(a + 1, 255));
                c = int'($urandom_range(0, 254));
                d = int'($urandom_range(c + 1, 255));
            end
            run_op($sformatf("rnd%0d", k), a, b, c, d, k[0]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
